// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer so in_ready is registered,
// plus flush-to-bubble and saturating stall/flush event counters.
module pipe_skid_stage #(
  parameter int unsigned        DATA_W         = 32,
  parameter int unsigned        TAG_W          = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE      = '0,
  parameter bit                 FLUSH_KEEP_TAG = 1'b1,
  parameter int unsigned        CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              push, pop;

  // in_ready depends only on the skid flop and flush, never on out_ready.
  assign in_ready = ~skid_valid_q & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_data_d   = NOP_VALUE;
      out_tag_d    = FLUSH_KEEP_TAG ? in_tag : '0;
    end else if (!out_valid_q) begin
      if (push) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_tag_d   = in_tag;
      end
    end else if (!skid_valid_q) begin
      if (push && pop) begin
        out_data_d = in_data;
        out_tag_d  = in_tag;
      end else if (push) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_tag_d   = in_tag;
      end else if (pop) begin
        out_valid_d = 1'b0;
      end
    end else if (pop) begin
      skid_valid_d = 1'b0;
      out_data_d   = skid_data_q;
      out_tag_d    = skid_tag_q;
    end
  end

  // Event counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= NOP_VALUE;
      out_tag_q    <= '0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline-stage register that generalises the fetch/decode boundary register into a reusable stage between any two CPU pipeline stages.
- Carries a payload (instruction) plus a sideband tag (e.g. PC+4) under a valid/ready handshake.
- A two-entry skid buffer lets the upstream stage see a registered ready, so back-pressure does not form a combinational path.
- Supports flush-to-bubble with selectable tag retention and exposes a stall/flush event counter for performance debug.

Parameters:
- DATA_W, 32, payload width (instruction word).
- TAG_W, 32, sideband tag width (PC+4 or similar).
- NOP_VALUE, 0, payload value presented on out_data after reset or flush.
- FLUSH_KEEP_TAG, 1, 1: on flush out_tag loads in_tag; 0: out_tag clears to 0.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat; equals ~skid_valid & ~flush.
- in_data  input  DATA_W  upstream payload.
- in_tag  input  TAG_W  upstream tag.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  main entry payload.
- out_tag  output  TAG_W  main entry tag.
- flush  input  1  synchronous flush; discards all held beats.
- occupancy  output  2  number of held beats, 0..2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  output  CNT_W  cycles with flush=1.

Behaviour:
- Reset (reset=0, async): out_valid=0, skid_valid=0, out_data=NOP_VALUE, out_tag=0, occupancy=0, stall_cnt=0, flush_cnt=0, in_ready=1 (given flush=0).
- Storage: main register (drives outputs) and skid register (hidden). States by occupancy: EMPTY(0), ONE(1), FULL(2).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY:
  - push loads main -> ONE.
  - Otherwise hold.
- ONE:
  - push & pop: main loads input -> ONE.
  - push & ~pop: input goes to skid -> FULL.
  - pop & ~push -> EMPTY.
  - Otherwise hold.
- FULL (in_ready=0):
  - pop: main loads skid, skid_valid=0 -> ONE.
  - Otherwise hold.
  - Input is ignored.
- Latency: 1 cycle from push to out_valid in EMPTY. Throughput is 1 beat/cycle when out_ready is held high.
- Ordering: strictly FIFO; the skid beat never overtakes the main beat.
- in_ready is a function of the skid_valid flop and flush only. It never depends on out_ready.
- Flush (highest priority after reset):
  - Next edge: out_valid=0, skid_valid=0, out_data=NOP_VALUE, occupancy=0.
  - out_tag takes in_tag if FLUSH_KEEP_TAG=1, else 0.
  - A simultaneous push is discarded (in_ready forced 0 that cycle). A simultaneous pop still completes downstream that cycle.
- Data regs hold their value while not loading; out_data is not cleared on pop, only out_valid drops.
- Counters:
  - stall_cnt increments each cycle with out_valid & ~out_ready & ~flush.
  - flush_cnt increments each cycle with flush=1.
  - Both saturate at all-ones (no wrap). Cleared only by reset.
- Reset asserted mid-transfer: all state clears immediately. No beat survives.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, out_tag=0, in_ready=1, occupancy=0, counters 0.
- Streaming: out_ready=1, push 0x11111111/0x4, 0x22222222/0x8, 0x33333333/0xC on consecutive cycles -> each appears on out_data/out_tag exactly one cycle later, occupancy stays 1, stall_cnt=0.
- Back-pressure: out_ready=0, push A then B -> occupancy=2, in_ready=0.
  - Third beat C is held upstream and not lost.
  - Raise out_ready -> A, B, C emerge in order. stall_cnt counts the held cycles.
- Flush with FLUSH_KEEP_TAG=1 while FULL, in_tag=0x40, in_valid=1 -> next cycle out_valid=0, out_data=NOP_VALUE, out_tag=0x40, occupancy=0, flush_cnt=1.
  - The concurrent input beat is dropped.
- Flush with FLUSH_KEEP_TAG=0 -> out_tag=0. Deassert flush, push D -> D appears after 1 cycle.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays there. Async reset asserted mid-stall clears all outputs without waiting for a clk edge.
